// File: rtl/conv_result_sink.sv
// Captures one frame of signed convolution results as clamped 8-bit pixels,
// then streams the frame out in address order over a valid/ready port.
module conv_result_sink #(
  parameter int AddressBitWidth = 17,
  parameter int ResultBitWidth  = 20,
  parameter int PixelBitWidth   = 8,
  parameter int NoOfRows        = 50,
  parameter int NoOfColumns     = 50,
  parameter int Shift           = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       WriteEnable,
  input  logic [AddressBitWidth-1:0] WriteAddress,
  input  logic [ResultBitWidth-1:0]  d_out,
  output logic                       armed,
  output logic                       frame_done,
  output logic                       addr_err,
  output logic                       ovr_err,
  output logic                       rd_valid,
  output logic [PixelBitWidth-1:0]   rd_data,
  output logic                       rd_last,
  input  logic                       rd_ready
);

  localparam int Depth = NoOfRows * NoOfColumns;
  localparam int CntW  = $clog2(Depth + 1);
  localparam int MemW  = $clog2(Depth);
  localparam logic [CntW-1:0]            LastIdx   = CntW'(Depth - 1);
  localparam logic [CntW-1:0]            DepthCnt  = CntW'(Depth);
  localparam logic [AddressBitWidth-1:0] DepthAddr = AddressBitWidth'(Depth);

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, DONE} state_t;

  state_t state_q, state_d;

  logic [1:0]               rst_sync;
  logic                     run;
  logic [CntW-1:0]          wr_cnt;
  logic [CntW-1:0]          rd_cnt;
  logic                     m_valid;
  logic                     m_last;
  logic [PixelBitWidth-1:0] mem_q;
  logic [PixelBitWidth-1:0] mem [Depth];

  logic signed [ResultBitWidth-1:0] shifted;
  logic [PixelBitWidth-1:0]         pixel;
  logic                             enter_cap;
  logic                             cap_wr;
  logic                             store;
  logic                             illegal_wr;
  logic                             out_load;
  logic                             issue;

  // Reset asserts asynchronously but releases through two flops, so the FSM
  // only starts reacting from the third clock edge after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync <= '0;
    else      rst_sync <= {rst_sync[0], 1'b1};
  end

  assign run = rst_sync[1];

  always_comb begin
    shifted = $signed(d_out) >>> Shift;
    pixel   = shifted[PixelBitWidth-1:0];
    if (shifted[ResultBitWidth-1])                          pixel = '0;
    else if (|shifted[ResultBitWidth-2:PixelBitWidth])      pixel = '1;
  end

  // The output register reloads when empty or accepted; the RAM read stage
  // keeps its value while stalled, so it doubles as the holding register.
  always_comb begin
    enter_cap  = run && start && (state_q == IDLE || state_q == DONE);
    cap_wr     = (state_q == CAPTURE) && WriteEnable;
    store      = cap_wr && (WriteAddress < DepthAddr);
    illegal_wr = WriteEnable && (state_q != CAPTURE);
    out_load   = (state_q == DRAIN) && (!rd_valid || rd_ready);
    issue      = (state_q == DRAIN) && (rd_cnt != DepthCnt) && (!m_valid || out_load);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enter_cap) state_d = CAPTURE;
      CAPTURE: if (cap_wr && wr_cnt == LastIdx) state_d = DRAIN;
      DRAIN:   if (rd_valid && rd_ready && rd_last) state_d = DONE;
      DONE:    if (enter_cap) state_d = CAPTURE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (store) mem[WriteAddress[MemW-1:0]] <= pixel;
    if (issue) mem_q <= mem[rd_cnt[MemW-1:0]];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      armed      <= 1'b0;
      frame_done <= 1'b0;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      addr_err   <= 1'b0;
      ovr_err    <= 1'b0;
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      rd_last    <= 1'b0;
    end else begin
      state_q    <= state_d;
      armed      <= (state_d == CAPTURE);
      frame_done <= (state_d == DONE);
      ovr_err    <= (enter_cap ? 1'b0 : ovr_err) | illegal_wr;

      if (enter_cap) begin
        wr_cnt   <= '0;
        rd_cnt   <= '0;
        addr_err <= 1'b0;
        m_valid  <= 1'b0;
      end else begin
        if (cap_wr) begin
          wr_cnt <= wr_cnt + 1'b1;
          if (WriteAddress != AddressBitWidth'(wr_cnt)) addr_err <= 1'b1;
        end
        if (issue) begin
          rd_cnt  <= rd_cnt + 1'b1;
          m_valid <= 1'b1;
          m_last  <= (rd_cnt == LastIdx);
        end else if (out_load) begin
          m_valid <= 1'b0;
        end
      end

      if (state_d != DRAIN) begin
        rd_valid <= 1'b0;
        rd_last  <= 1'b0;
      end else if (out_load) begin
        rd_valid <= m_valid;
        rd_last  <= m_valid && m_last;
        if (m_valid) rd_data <= mem_q;
      end
    end
  end

endmodule

// File: tb/tb_conv_result_sink.sv
// Scoreboard bench for conv_result_sink: a pixel model fills an expected queue
// per frame, and the drain loop pops and compares each transferred beat.
module tb_conv_result_sink;

  localparam int Depth       = 2500;
  localparam int DrainBudget = 20000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        WriteEnable;
  logic [16:0] WriteAddress;
  logic [19:0] d_out;
  logic        armed;
  logic        frame_done;
  logic        addr_err;
  logic        ovr_err;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        rd_last;
  logic        rd_ready;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  model_mem [Depth];
  logic [7:0]  exp_q [$];
  logic [7:0]  cap [3];

  conv_result_sink dut (
    .clk(clk), .rst(rst), .start(start), .WriteEnable(WriteEnable),
    .WriteAddress(WriteAddress), .d_out(d_out), .armed(armed),
    .frame_done(frame_done), .addr_err(addr_err), .ovr_err(ovr_err),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .rd_ready(rd_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] conv(input int d);
    int q;
    if (d < 0) return 8'd0;
    q = d / 128;
    if (q > 255) return 8'd255;
    return 8'(q);
  endfunction

  function automatic int dval(input int kind, input int a);
    case (kind)
      0: return 128 * (a % 256);
      1: begin
        if (a == 0) return -500;
        if (a == 1) return 12800;
        if (a == 2) return 40000;
        return 128 * ((a * 7 + 3) % 256) + (a % 128);
      end
      default: return ((a * 37) % 700) * 64 - 5000;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic start_pulse();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic write_one(input int a, input int kind);
    int d;
    d = dval(kind, a);
    @(negedge clk);
    WriteEnable  = 1'b1;
    WriteAddress = 17'(a);
    d_out        = 20'(d);
    if (a < Depth) model_mem[a] = conv(d);
  endtask

  task automatic write_range(input int lo, input int hi, input int kind);
    for (int a = lo; a <= hi; a++) write_one(a, kind);
  endtask

  task automatic end_writes();
    @(negedge clk); WriteEnable = 1'b0;
  endtask

  task automatic push_frame();
    for (int a = 0; a < Depth; a++) exp_q.push_back(model_mem[a]);
  endtask

  // Called at the negedge right after the last capture write committed.
  task automatic drain_frame(input bit rand_ready, input int pulse_at, input int stop_beats);
    int cycles, beats, first_valid;
    bit prev_stall, rdy, exp_last;
    logic [7:0] prev_data, exp_px;
    logic prev_last;
    cycles = 0; beats = 0; first_valid = -1;
    prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    while (beats < stop_beats && cycles < DrainBudget) begin
      if (prev_stall) begin
        n_checks++;
        if (rd_valid !== 1'b1 || rd_data !== prev_data || rd_last !== prev_last) begin
          n_fail++;
          $display("[TB] FAIL stall_hold: got valid=%b data=%0d last=%b expected valid=1 data=%0d last=%b",
                   rd_valid, rd_data, rd_last, prev_data, prev_last);
        end
      end
      if (rd_valid === 1'b1 && first_valid < 0) first_valid = cycles;
      if (!rand_ready && first_valid >= 0) begin
        n_checks++;
        if (rd_valid !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL no_bubble: got rd_valid=%b expected 1 at beat %0d", rd_valid, beats);
        end
      end
      if (cycles == pulse_at) begin
        WriteEnable = 1'b1; WriteAddress = 17'd2400; d_out = 20'(128 * 99);
      end else if (cycles == pulse_at + 1) begin
        WriteEnable = 1'b0;
      end
      rdy = rand_ready ? ($urandom_range(0, 99) < 55) : 1'b1;
      rd_ready = rdy;
      if (rd_valid === 1'b1 && rdy) begin
        exp_last = (beats == Depth - 1);
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("[TB] FAIL extra_beat: got data=%0d expected no beat", rd_data);
        end else begin
          exp_px = exp_q.pop_front();
          if (rd_data !== exp_px) begin
            n_fail++;
            $display("[TB] FAIL beat_data[%0d]: got %0d expected %0d", beats, rd_data, exp_px);
          end
          n_checks++;
          if (rd_last !== exp_last) begin
            n_fail++;
            $display("[TB] FAIL beat_last[%0d]: got %b expected %b", beats, rd_last, exp_last);
          end
        end
        if (beats < 3) cap[beats] = rd_data;
        beats++;
      end
      prev_stall = (rd_valid === 1'b1) && !rdy;
      prev_data  = rd_data;
      prev_last  = rd_last;
      @(negedge clk);
      cycles++;
    end
    WriteEnable = 1'b0;
    rd_ready    = 1'b0;
    n_checks++;
    if (beats != stop_beats) begin
      n_fail++;
      $display("[TB] FAIL drain_beats: got %0d expected %0d", beats, stop_beats);
    end
    n_checks++;
    if (first_valid < 0 || first_valid > 2) begin
      n_fail++;
      $display("[TB] FAIL first_valid_latency: got %0d expected 0..2", first_valid);
    end
  endtask

  task automatic test_reset();
    int waited;
    rst = 1'b0; start = 1'b0; WriteEnable = 1'b0; WriteAddress = '0; d_out = '0; rd_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({armed, frame_done, addr_err, ovr_err, rd_valid, rd_last} !== 6'b0 || rd_data !== 8'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_values: got flags=%b data=%0d expected flags=000000 data=0",
               {armed, frame_done, addr_err, ovr_err, rd_valid, rd_last}, rd_data);
    end
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    n_checks++;
    if (armed !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_sync_first_edge: got armed=%b expected 0", armed);
    end
    waited = 0;
    while (armed !== 1'b1 && waited < 6) begin
      @(negedge clk); waited++;
    end
    start = 1'b0;
    n_checks++;
    if (armed !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reset_release_start: got armed=%b expected 1", armed);
    end
    do_reset();
  endtask

  task automatic test_basic();
    start_pulse();
    n_checks++;
    if (armed !== 1'b1 || frame_done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL basic_armed: got armed=%b done=%b expected armed=1 done=0", armed, frame_done);
    end
    write_range(0, 1249, 0);
    n_checks++;
    if (armed !== 1'b1 || addr_err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL basic_mid_capture: got armed=%b addr_err=%b expected 1 0", armed, addr_err);
    end
    write_range(1250, 2499, 0);
    end_writes();
    n_checks++;
    if (armed !== 1'b0 || frame_done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL basic_enter_drain: got armed=%b done=%b expected 0 0", armed, frame_done);
    end
    push_frame();
    drain_frame(1'b0, -1, Depth);
    n_checks++;
    if (frame_done !== 1'b1 || addr_err !== 1'b0 || ovr_err !== 1'b0 || rd_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL basic_done: got done=%b addr_err=%b ovr_err=%b valid=%b expected 1 0 0 0",
               frame_done, addr_err, ovr_err, rd_valid);
    end
  endtask

  task automatic test_clamp();
    start_pulse();
    write_range(0, 2499, 1);
    end_writes();
    push_frame();
    drain_frame(1'b0, -1, Depth);
    n_checks++;
    if (cap[0] !== 8'd0 || cap[1] !== 8'd100 || cap[2] !== 8'd255) begin
      n_fail++;
      $display("[TB] FAIL clamp_pixels: got %0d %0d %0d expected 0 100 255", cap[0], cap[1], cap[2]);
    end
  endtask

  task automatic test_backpressure();
    start_pulse();
    write_range(0, 2499, 2);
    end_writes();
    push_frame();
    drain_frame(1'b1, -1, Depth);
    @(negedge clk);
    n_checks++;
    if (rd_valid !== 1'b0 || frame_done !== 1'b1 || exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL backpressure_end: got valid=%b done=%b left=%0d expected 0 1 0",
               rd_valid, frame_done, exp_q.size());
    end
  endtask

  task automatic test_illegal();
    start_pulse();
    write_range(0, 99, 0);
    write_one(100, 0);
    start = 1'b1;
    write_one(101, 0);
    start = 1'b0;
    write_range(102, 2499, 0);
    n_checks++;
    if (armed !== 1'b1 || addr_err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL start_in_capture: got armed=%b addr_err=%b expected 1 0", armed, addr_err);
    end
    end_writes();
    n_checks++;
    if (armed !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL capture_length: got armed=%b expected 0", armed);
    end
    push_frame();
    drain_frame(1'b0, 500, Depth);
    n_checks++;
    if (ovr_err !== 1'b1 || addr_err !== 1'b0 || frame_done !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL drain_write: got ovr_err=%b addr_err=%b done=%b expected 1 0 1",
               ovr_err, addr_err, frame_done);
    end
    do_reset();
    @(negedge clk);
    WriteEnable = 1'b1; WriteAddress = 17'd2; d_out = 20'(128 * 77);
    @(negedge clk);
    WriteEnable = 1'b0;
    n_checks++;
    if (ovr_err !== 1'b1 || armed !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL idle_write: got ovr_err=%b armed=%b expected 1 0", ovr_err, armed);
    end
  endtask

  task automatic test_seq_err();
    start_pulse();
    n_checks++;
    if (ovr_err !== 1'b0 || addr_err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL capture_clears_errors: got ovr_err=%b addr_err=%b expected 0 0", ovr_err, addr_err);
    end
    write_one(0, 0);
    write_one(1, 0);
    write_one(3, 0);
    n_checks++;
    if (addr_err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL seq_before_gap: got addr_err=%b expected 0", addr_err);
    end
    write_one(4, 0);
    n_checks++;
    if (addr_err !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL seq_after_gap: got addr_err=%b expected 1", addr_err);
    end
    write_range(5, 2500, 0);
    end_writes();
    n_checks++;
    if (armed !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL seq_capture_length: got armed=%b expected 0", armed);
    end
    push_frame();
    drain_frame(1'b0, -1, Depth);
    n_checks++;
    if (addr_err !== 1'b1 || frame_done !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL seq_done: got addr_err=%b done=%b expected 1 1", addr_err, frame_done);
    end
  endtask

  task automatic test_reset_mid_drain();
    start_pulse();
    write_range(0, 2499, 0);
    end_writes();
    push_frame();
    drain_frame(1'b0, 300, 1000);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({armed, frame_done, addr_err, ovr_err, rd_valid, rd_last} !== 6'b0 || rd_data !== 8'd0) begin
      n_fail++;
      $display("[TB] FAIL async_reset: got flags=%b data=%0d expected flags=000000 data=0",
               {armed, frame_done, addr_err, ovr_err, rd_valid, rd_last}, rd_data);
    end
    exp_q.delete();
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    start_pulse();
    n_checks++;
    if (armed !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL restart_armed: got %b expected 1", armed);
    end
    write_range(0, 2499, 2);
    end_writes();
    push_frame();
    drain_frame(1'b0, -1, Depth);
    n_checks++;
    if (frame_done !== 1'b1 || addr_err !== 1'b0 || ovr_err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL restart_done: got done=%b addr_err=%b ovr_err=%b expected 1 0 0",
               frame_done, addr_err, ovr_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_backpressure();
    test_illegal();
    test_seq_err();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_result_sink.md
CONV_RESULT_SINK -- requirements
Module: conv_result_sink

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- AddressBitWidth, 17, write address width.
- ResultBitWidth, 20, signed convolution result width.
- PixelBitWidth, 8, unsigned stored pixel width.
- NoOfRows, 50, frame rows.
- NoOfColumns, 50, frame columns.
- Shift, 7, arithmetic right-shift applied to results.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, the only clock.
- rst, in, 1, asynchronous, active-low reset.
- start, in, 1, arm capture of one frame.
- WriteEnable, in, 1, result strobe from the conv engine.
- WriteAddress, in, AddressBitWidth, result index.
- d_out, in, ResultBitWidth, signed result.
- armed, out, 1, high in CAPTURE.
- frame_done, out, 1, high in DONE.
- addr_err, out, 1, sticky sequence error.
- ovr_err, out, 1, sticky write-outside-CAPTURE error.
- rd_valid, out, 1, drain data valid.
- rd_data, out, PixelBitWidth, drained pixel.
- rd_last, out, 1, final pixel of frame.
- rd_ready, in, 1, host accept.

Function
REQ-003 The block SHALL hold an internal NoOfRows*NoOfColumns x PixelBitWidth memory (2500 words at defaults), with synchronous read of one cycle latency.

REQ-004 The FSM SHALL have states IDLE, CAPTURE, DRAIN and DONE.
- IDLE to CAPTURE on start.
- CAPTURE to DRAIN the cycle after the 2500th accepted write.
- DRAIN to DONE on the handshake of the rd_last beat.
- DONE to CAPTURE on start.

REQ-005 Entering CAPTURE SHALL clear the write counter, the read counter, addr_err and ovr_err.

REQ-006 start SHALL be ignored in CAPTURE and DRAIN.

REQ-007 In CAPTURE, each cycle with WriteEnable=1 SHALL count as one accepted write.
- The pixel is stored at WriteAddress when WriteAddress < 2500.
- The write is dropped when WriteAddress >= 2500, but it still counts.

REQ-008 If an accepted write's WriteAddress differs from the write counter, addr_err SHALL be set and stay set until the next CAPTURE entry.

REQ-009 Pixel conversion SHALL be: arithmetic right shift of d_out by Shift, then clamp to 0..2^PixelBitWidth-1.
- Negative values become 0.
- Values above 255 become 255.

REQ-010 A WriteEnable pulse in IDLE, DRAIN or DONE SHALL NOT modify memory and SHALL set ovr_err.

REQ-011 The drain interface SHALL use valid/ready handshaking.
- A beat transfers when rd_valid and rd_ready are both 1.
- While rd_valid=1 and rd_ready=0, rd_data, rd_last and rd_valid SHALL hold stable.

REQ-012 The drain SHALL output pixels in address order 0..2499.
- The first rd_valid SHALL rise no later than 2 cycles after entering DRAIN.
- With rd_ready held at 1, one pixel SHALL transfer per cycle with no bubbles.

REQ-013 rd_last SHALL be 1 only on the beat carrying address 2499.

REQ-014 In DRAIN, the memory read and output stages SHALL form a pipeline without loss or duplication under arbitrary rd_ready patterns, using a skid/holding register as needed.

REQ-015 armed SHALL equal (state==CAPTURE) and frame_done SHALL equal (state==DONE); both are registered.

REQ-016 rd_valid SHALL be 0 outside DRAIN.

REQ-017 Memory contents SHALL persist from DONE into the next CAPTURE; only written locations change.

Reset
REQ-018 When rst=0, the block SHALL go immediately to IDLE, regardless of clk.

REQ-019 Reset values SHALL be:
- armed=0, frame_done=0, addr_err=0, ovr_err=0, rd_valid=0, rd_data=0, rd_last=0.
- Write and read counters 0.

REQ-020 Reset asserted mid-CAPTURE or mid-DRAIN SHALL abort the frame; memory contents are not cleared.

REQ-021 Release of rst SHALL be synchronised internally so that the first state change occurs no earlier than the second rising clk edge after release.

Verification
REQ-022 Bench scenario, basic capture and drain:
- Stimulus: start, then 2500 sequential writes with d_out = 128*(addr mod 256), then drain with rd_ready=1.
- Response: rd_data = addr mod 256 for every addr; rd_last only at addr 2499; frame_done=1 afterwards; addr_err=0.

REQ-023 Bench scenario, clamping:
- Stimulus: d_out = -500, 12800 and 40000 at addresses 0, 1 and 2.
- Response: drained pixels 0, 100 and 255.

REQ-024 Bench scenario, backpressure:
- Stimulus: rd_ready toggles in a pseudo-random pattern during the drain.
- Response: exactly 2500 beats, in order, with no duplicates; rd_data stable while stalled.

REQ-025 Bench scenario, sequence error:
- Stimulus: write sequence 0, 1, 3, ...
- Response: addr_err=1 from the cycle after address 3 is accepted, and it remains 1 through DONE.

REQ-026 Bench scenario, illegal writes:
- Stimulus: a WriteEnable pulse in IDLE, and start asserted in CAPTURE.
- Response: ovr_err=1 and memory unchanged; the start in CAPTURE does not clear the write counter.

REQ-027 Bench scenario, reset mid-drain:
- Stimulus: rst=0 asynchronously at beat 1000, then release, start, and a full new frame.
- Response: all outputs go to reset values immediately; the new frame drains correctly from address 0.
